branch_resolve_unit: RTL and testbench
======================================

Name: branch_resolve_unit

Overview:
Parametrised successor to the EX-stage branch comparator. It evaluates all six RV32I conditional-branch conditions plus JAL/JALR, computes the target, and checks the result against the fetch-stage prediction. The result is registered, one cycle of latency, and drives the IF redirect. The block also squashes wrong-path results after a mispredict and keeps saturating branch and mispredict counters.

Parameters:
XLEN, 32, operand/PC/target width
CNT_W, 16, width of the statistics counters
SHADOW, 2, number of accepted inputs squashed after a mispredict is captured (0 disables; 0..7)

Ports:
clk  in  1  clock
rst  in  1  synchronous, active-high reset
in_valid  in  1  control-flow instruction present in EX this cycle
stall  in  1  hold all state and outputs
flush  in  1  external pipeline flush
op_kind  in  2  00 cond branch, 01 JAL, 10 JALR, 11 reserved
funct3  in  3  branch condition (used when op_kind=00)
rs1  in  XLEN  operand 1
rs2  in  XLEN  operand 2
pc  in  XLEN  instruction PC
imm  in  XLEN  sign-extended offset
pred_taken  in  1  fetch prediction: taken
pred_target  in  XLEN  fetch prediction: target
out_valid  out  1  registered result valid
taken  out  1  resolved direction
target  out  XLEN  resolved target (valid even if not taken)
mispredict  out  1  redirect required
redirect_pc  out  XLEN  taken ? target : pc+4
illegal  out  1  op_kind=11 or funct3 in {010,011}
br_count  out  CNT_W  resolved (non-squashed) results
mis_count  out  CNT_W  mispredicts

Behaviour:
- Reset (rst=1 at posedge): all outputs 0; shadow counter 0; FSM in RUN. Reset wins over stall and flush.
- Conditions: funct3 000 BEQ, 001 BNE, 100 BLT (signed), 101 BGE (signed), 110 BLTU, 111 BGEU. 010/011: taken=0, illegal=1.
- JAL: taken=1, target=pc+imm.
- JALR: taken=1, target=(rs1+imm) with bit0 cleared.
- Cond branch: target=pc+imm.
- op_kind=11: taken=0, illegal=1.
- All adds are modulo 2^XLEN (wrap silently).
- mispredict = taken!=pred_taken, or (taken && target!=pred_target). Illegal entries have mispredict=0.
- Latency: inputs sampled at posedge N; outputs valid after posedge N, stable until the next non-stalled edge.
- Priority at each posedge: rst > flush > stall > capture.
  - flush=1: out_valid=0, mispredict=0, FSM to RUN, shadow counter cleared. Other data outputs may hold. Counters unchanged.
  - stall=1 (no flush): every register holds, including out_valid, mispredict and the counters.
  - capture (no stall/flush): out_valid <= in_valid && state==RUN. Data registers load. mispredict <= valid && mispredict_comb.
- FSM states:
  - RUN: a capture with out_valid=1 and mispredict=1 moves to SQUASH with cnt=SHADOW. If SHADOW=0, stay in RUN.
  - SQUASH: each non-stalled, non-flushed cycle with in_valid=1 decrements cnt. The squashed input gives out_valid=0 and is not counted. On cnt reaching 0, return to RUN. Cycles with in_valid=0 do not decrement.
- Counters:
  - br_count increments on each capture with out_valid becoming 1.
  - mis_count increments when mispredict becomes 1.
  - Both saturate at 2^CNT_W-1 and never wrap.
- Back-to-back valid branches are accepted every cycle in RUN; there is no backpressure output.

Decomposition:
- Package branch_pkg holds:
  - op_kind encodings (OP_BR, OP_JAL, OP_JALR, OP_RSV);
  - funct3 constants (F3_BEQ..F3_BGEU);
  - FSM state enum {ST_RUN, ST_SQUASH}.
- One combinational sub-module, branch_cond_eval (XLEN param), produces cond_taken and cond_illegal from rs1, rs2, funct3. Reuse it in any later branch-predictor checker.

Test Plan:
- Signed vs unsigned: rs1=0xFFFFFFFF, rs2=0x00000001, sweep funct3 100/101/110/111 -> taken = 1,0,0,1. BEQ with rs1=rs2=5 -> taken=1, and target=pc+imm one cycle later.
- JALR alignment and wrap: rs1=0xFFFFFFFE, imm=3, pred_taken=1, pred_target=0 -> target=0x00000000, mispredict=0. Same with pred_target=4 -> mispredict=1, redirect_pc=0.
- Shadow (SHADOW=2): mispredicting BNE followed by 3 consecutive valid branches -> next two results have out_valid=0, the third is valid; br_count=2, mis_count=1. Repeat with an idle cycle inserted -> the idle cycle does not consume shadow.
- Stall/flush: a valid branch is captured, then stall held 3 cycles -> outputs and counters frozen. flush asserted together with stall -> out_valid=0 next edge, and a subsequent mispredict is not shadowed.
- Saturation (CNT_W=3): 10 mispredicting branches with SHADOW=0 -> br_count=mis_count=7, no wrap. Then rst -> all outputs and counters 0 on the next edge.
- Illegal: funct3=010 with pred_taken=1 -> illegal=1, taken=0, mispredict=0, redirect_pc=pc+4.

Source files
------------

// File: rtl/branch_pkg.sv
// Shared encodings for the EX-stage branch resolve unit: op kinds, branch
// funct3 codes and the wrong-path squash FSM states.
package branch_pkg;

  typedef enum logic [1:0] {
    OP_BR   = 2'b00,
    OP_JAL  = 2'b01,
    OP_JALR = 2'b10,
    OP_RSV  = 2'b11
  } op_kind_e;

  localparam logic [2:0] F3_BEQ  = 3'b000;
  localparam logic [2:0] F3_BNE  = 3'b001;
  localparam logic [2:0] F3_BLT  = 3'b100;
  localparam logic [2:0] F3_BGE  = 3'b101;
  localparam logic [2:0] F3_BLTU = 3'b110;
  localparam logic [2:0] F3_BGEU = 3'b111;

  typedef enum logic {
    ST_RUN,
    ST_SQUASH
  } state_e;

endpackage

// File: rtl/branch_resolve_unit_if.sv
// EX-stage request / resolved-result bundle for branch_resolve_unit.
interface branch_resolve_unit_if #(
  parameter int unsigned XLEN  = 32,
  parameter int unsigned CNT_W = 16
);
  logic            in_valid;
  logic            stall;
  logic            flush;
  logic [1:0]      op_kind;
  logic [2:0]      funct3;
  logic [XLEN-1:0] rs1;
  logic [XLEN-1:0] rs2;
  logic [XLEN-1:0] pc;
  logic [XLEN-1:0] imm;
  logic            pred_taken;
  logic [XLEN-1:0] pred_target;

  logic             out_valid;
  logic             taken;
  logic [XLEN-1:0]  target;
  logic             mispredict;
  logic [XLEN-1:0]  redirect_pc;
  logic             illegal;
  logic [CNT_W-1:0] br_count;
  logic [CNT_W-1:0] mis_count;

  modport master (
    output in_valid, stall, flush, op_kind, funct3, rs1, rs2, pc, imm,
           pred_taken, pred_target,
    input  out_valid, taken, target, mispredict, redirect_pc, illegal,
           br_count, mis_count
  );

  modport slave (
    input  in_valid, stall, flush, op_kind, funct3, rs1, rs2, pc, imm,
           pred_taken, pred_target,
    output out_valid, taken, target, mispredict, redirect_pc, illegal,
           br_count, mis_count
  );
endinterface

// File: rtl/branch_cond_eval.sv
// Combinational RV32I conditional-branch evaluator; reusable by any checker
// that needs the architectural branch outcome.
module branch_cond_eval
  import branch_pkg::*;
#(
  parameter int unsigned XLEN = 32
) (
  input  logic [XLEN-1:0] rs1_i,
  input  logic [XLEN-1:0] rs2_i,
  input  logic [2:0]      funct3_i,
  output logic            cond_taken_o,
  output logic            cond_illegal_o
);

  always_comb begin
    cond_taken_o   = 1'b0;
    cond_illegal_o = 1'b0;
    case (funct3_i)
      F3_BEQ:  cond_taken_o = (rs1_i == rs2_i);
      F3_BNE:  cond_taken_o = (rs1_i != rs2_i);
      F3_BLT:  cond_taken_o = ($signed(rs1_i) <  $signed(rs2_i));
      F3_BGE:  cond_taken_o = ($signed(rs1_i) >= $signed(rs2_i));
      F3_BLTU: cond_taken_o = (rs1_i <  rs2_i);
      F3_BGEU: cond_taken_o = (rs1_i >= rs2_i);
      default: cond_illegal_o = 1'b1;
    endcase
  end

endmodule

// File: rtl/branch_resolve_unit.sv
// EX-stage branch/jump resolver: registered outcome and IF redirect, wrong-path
// squash after a mispredict, saturating branch and mispredict statistics.
module branch_resolve_unit
  import branch_pkg::*;
#(
  parameter int unsigned XLEN   = 32,
  parameter int unsigned CNT_W  = 16,
  parameter int unsigned SHADOW = 2
) (
  input logic                  clk,
  input logic                  rst,
  branch_resolve_unit_if.slave bus
);

  localparam logic [XLEN-1:0] PC_STEP = XLEN'(4);

  op_kind_e        op;
  logic            cond_taken;
  logic            cond_illegal;
  logic            taken_c;
  logic            illegal_c;
  logic            mis_c;
  logic            accept;
  logic [XLEN-1:0] jalr_sum;
  logic [XLEN-1:0] target_c;
  logic [XLEN-1:0] redirect_c;

  state_e           state_q;
  logic [2:0]       sq_cnt_q;
  logic             out_valid_q;
  logic             taken_q;
  logic [XLEN-1:0]  target_q;
  logic             mispredict_q;
  logic [XLEN-1:0]  redirect_q;
  logic             illegal_q;
  logic [CNT_W-1:0] br_count_q;
  logic [CNT_W-1:0] mis_count_q;

  assign op = op_kind_e'(bus.op_kind);

  branch_cond_eval #(.XLEN(XLEN)) u_cond (
    .rs1_i          (bus.rs1),
    .rs2_i          (bus.rs2),
    .funct3_i       (bus.funct3),
    .cond_taken_o   (cond_taken),
    .cond_illegal_o (cond_illegal)
  );

  assign jalr_sum = bus.rs1 + bus.imm;

  always_comb begin
    taken_c   = 1'b0;
    illegal_c = 1'b0;
    target_c  = bus.pc + bus.imm;
    case (op)
      OP_BR: begin
        taken_c   = cond_taken;
        illegal_c = cond_illegal;
      end
      OP_JAL:  taken_c = 1'b1;
      OP_JALR: begin
        taken_c  = 1'b1;
        target_c = {jalr_sum[XLEN-1:1], 1'b0};
      end
      OP_RSV:  illegal_c = 1'b1;
    endcase
  end

  // Illegal entries never redirect, whatever fetch predicted.
  assign mis_c = !illegal_c &&
                 ((taken_c != bus.pred_taken) ||
                  (taken_c && (target_c != bus.pred_target)));
  assign redirect_c = taken_c ? target_c : (bus.pc + PC_STEP);
  assign accept     = bus.in_valid && (state_q == ST_RUN);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_RUN;
      sq_cnt_q     <= '0;
      out_valid_q  <= 1'b0;
      taken_q      <= 1'b0;
      target_q     <= '0;
      mispredict_q <= 1'b0;
      redirect_q   <= '0;
      illegal_q    <= 1'b0;
      br_count_q   <= '0;
      mis_count_q  <= '0;
    end else if (bus.flush) begin
      state_q      <= ST_RUN;
      sq_cnt_q     <= '0;
      out_valid_q  <= 1'b0;
      mispredict_q <= 1'b0;
    end else if (!bus.stall) begin
      out_valid_q  <= accept;
      taken_q      <= taken_c;
      target_q     <= target_c;
      redirect_q   <= redirect_c;
      illegal_q    <= illegal_c;
      mispredict_q <= accept && mis_c;
      if (accept && (br_count_q != '1)) br_count_q <= br_count_q + 1'b1;
      if (accept && mis_c && (mis_count_q != '1)) mis_count_q <= mis_count_q + 1'b1;
      case (state_q)
        ST_RUN: begin
          if (accept && mis_c && (SHADOW != 0)) begin
            state_q  <= ST_SQUASH;
            sq_cnt_q <= 3'(SHADOW);
          end
        end
        ST_SQUASH: begin
          // Only real wrong-path instructions consume the shadow window.
          if (bus.in_valid) begin
            sq_cnt_q <= sq_cnt_q - 3'd1;
            if (sq_cnt_q == 3'd1) state_q <= ST_RUN;
          end
        end
      endcase
    end
  end

  assign bus.out_valid   = out_valid_q;
  assign bus.taken       = taken_q;
  assign bus.target      = target_q;
  assign bus.mispredict  = mispredict_q;
  assign bus.redirect_pc = redirect_q;
  assign bus.illegal     = illegal_q;
  assign bus.br_count    = br_count_q;
  assign bus.mis_count   = mis_count_q;

endmodule

// File: tb/tb_branch_resolve_unit.sv
// Bench for branch_resolve_unit: instance A (CNT_W=16, SHADOW=2) and instance B
// (CNT_W=3, SHADOW=0) share one stimulus stream and a behavioural model.
module tb_branch_resolve_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid, stall, flush, pred_taken;
  logic [1:0]  op_kind;
  logic [2:0]  funct3;
  logic [31:0] rs1, rs2, pc, imm, pred_target;

  int tests_run    = 0;
  int tests_failed = 0;
  bit started      = 1'b0;

  always #5 clk = ~clk;

  branch_resolve_unit_if #(.XLEN(32), .CNT_W(16)) if_a ();
  branch_resolve_unit_if #(.XLEN(32), .CNT_W(3))  if_b ();

  assign if_a.in_valid = in_valid;    assign if_b.in_valid = in_valid;
  assign if_a.stall = stall;          assign if_b.stall = stall;
  assign if_a.flush = flush;          assign if_b.flush = flush;
  assign if_a.op_kind = op_kind;      assign if_b.op_kind = op_kind;
  assign if_a.funct3 = funct3;        assign if_b.funct3 = funct3;
  assign if_a.rs1 = rs1;              assign if_b.rs1 = rs1;
  assign if_a.rs2 = rs2;              assign if_b.rs2 = rs2;
  assign if_a.pc = pc;                assign if_b.pc = pc;
  assign if_a.imm = imm;              assign if_b.imm = imm;
  assign if_a.pred_taken = pred_taken;    assign if_b.pred_taken = pred_taken;
  assign if_a.pred_target = pred_target;  assign if_b.pred_target = pred_target;

  branch_resolve_unit #(.XLEN(32), .CNT_W(16), .SHADOW(2)) dut_a (
    .clk (clk), .rst (rst), .bus (if_a.slave)
  );
  branch_resolve_unit #(.XLEN(32), .CNT_W(3), .SHADOW(0)) dut_b (
    .clk (clk), .rst (rst), .bus (if_b.slave)
  );

  // ---------------- behavioural model ----------------
  int          m_shadow [2] = '{2, 0};
  int          m_cmax   [2] = '{65535, 7};
  int          m_left   [2];
  int          m_br     [2];
  int          m_mis    [2];
  logic        m_valid  [2];
  logic        m_taken  [2];
  logic        m_mp     [2];
  logic        m_ill    [2];
  logic [31:0] m_target [2];
  logic [31:0] m_redir  [2];

  function automatic void resolve(input logic [1:0] o, input logic [2:0] f,
                                  input logic [31:0] a, input logic [31:0] b,
                                  input logic [31:0] p, input logic [31:0] i,
                                  output logic tk, output logic [31:0] tg,
                                  output logic il);
    tk = 1'b0; il = 1'b0; tg = p + i;
    case (o)
      2'd0: case (f)
        3'd0: tk = (a == b);
        3'd1: tk = (a != b);
        3'd4: tk = ($signed(a) <  $signed(b));
        3'd5: tk = ($signed(a) >= $signed(b));
        3'd6: tk = (a <  b);
        3'd7: tk = (a >= b);
        default: il = 1'b1;
      endcase
      2'd1: tk = 1'b1;
      2'd2: begin tk = 1'b1; tg = (a + i) & 32'hFFFF_FFFE; end
      default: il = 1'b1;
    endcase
  endfunction

  always @(posedge clk) begin
    logic        tk, il, mp;
    logic [31:0] tg;
    bit          acc;
    for (int k = 0; k < 2; k++) begin
      if (rst) begin
        m_left[k] = 0; m_br[k] = 0; m_mis[k] = 0;
        m_valid[k] = 0; m_taken[k] = 0; m_mp[k] = 0; m_ill[k] = 0;
        m_target[k] = '0; m_redir[k] = '0;
      end else if (flush) begin
        m_valid[k] = 0; m_mp[k] = 0; m_left[k] = 0;
      end else if (!stall) begin
        acc = in_valid && (m_left[k] == 0);
        if (in_valid && m_left[k] > 0) m_left[k]--;
        resolve(op_kind, funct3, rs1, rs2, pc, imm, tk, tg, il);
        mp = !il && ((tk != pred_taken) || (tk && tg != pred_target));
        m_valid[k] = acc;
        m_taken[k] = tk; m_target[k] = tg; m_ill[k] = il;
        m_redir[k] = tk ? tg : pc + 32'd4;
        m_mp[k]    = acc && mp;
        if (acc && m_br[k] < m_cmax[k]) m_br[k]++;
        if (acc && mp && m_mis[k] < m_cmax[k]) m_mis[k]++;
        if (acc && mp) m_left[k] = m_shadow[k];
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic cmp_inst(input int k, input string n, input logic ov, input logic tk,
                          input logic [31:0] tg, input logic mp, input logic [31:0] rp,
                          input logic il, input logic [31:0] bc, input logic [31:0] mc);
    chk({n, ".out_valid"},  32'(ov), 32'(m_valid[k]));
    chk({n, ".mispredict"}, 32'(mp), 32'(m_mp[k]));
    chk({n, ".br_count"},   bc, 32'(m_br[k]));
    chk({n, ".mis_count"},  mc, 32'(m_mis[k]));
    if (m_valid[k]) begin
      chk({n, ".taken"},       32'(tk), 32'(m_taken[k]));
      chk({n, ".target"},      tg, m_target[k]);
      chk({n, ".redirect_pc"}, rp, m_redir[k]);
      chk({n, ".illegal"},     32'(il), 32'(m_ill[k]));
    end
  endtask

  always @(negedge clk) begin
    if (started) begin
      cmp_inst(0, "A", if_a.out_valid, if_a.taken, if_a.target, if_a.mispredict,
               if_a.redirect_pc, if_a.illegal, 32'(if_a.br_count), 32'(if_a.mis_count));
      cmp_inst(1, "B", if_b.out_valid, if_b.taken, if_b.target, if_b.mispredict,
               if_b.redirect_pc, if_b.illegal, 32'(if_b.br_count), 32'(if_b.mis_count));
    end
  end

  // ---------------- stimulus ----------------
  task automatic cyc();
    @(negedge clk);
  endtask

  task automatic drive(input logic [1:0] o, input logic [2:0] f, input logic [31:0] a,
                       input logic [31:0] b, input logic [31:0] p, input logic [31:0] i,
                       input logic pt, input logic [31:0] ptg);
    in_valid = 1'b1; op_kind = o; funct3 = f; rs1 = a; rs2 = b; pc = p; imm = i;
    pred_taken = pt; pred_target = ptg;
  endtask

  task automatic idle();
    in_valid = 1'b0;
  endtask

  task automatic do_reset();
    idle(); stall = 1'b0; flush = 1'b0; rst = 1'b1;
    cyc();
    rst = 1'b0;
  endtask

  task automatic good_beq();
    drive(2'd0, 3'd0, 32'd7, 32'd7, 32'h400, 32'h10, 1'b1, 32'h410);
  endtask

  task automatic bad_bne();
    drive(2'd0, 3'd1, 32'd1, 32'd2, 32'h500, 32'h40, 1'b0, 32'h0);
  endtask

  initial begin
    logic [1:0] ro;
    rst = 1'b1; stall = 1'b0; flush = 1'b0;
    in_valid = 1'b0; op_kind = '0; funct3 = '0; rs1 = '0; rs2 = '0; pc = '0; imm = '0;
    pred_taken = 1'b0; pred_target = '0;
    cyc();
    rst = 1'b0;
    started = 1'b1;
    chk("reset.A.out_valid", 32'(if_a.out_valid), 0);
    chk("reset.A.target", if_a.target, 0);
    chk("reset.A.br_count", 32'(if_a.br_count), 0);

    // signed vs unsigned, predictions chosen correct so no shadow kicks in
    drive(2'd0, 3'd4, 32'hFFFF_FFFF, 32'h1, 32'h100, 32'h20, 1'b1, 32'h120); cyc();
    chk("BLT.taken", 32'(if_a.taken), 1);
    drive(2'd0, 3'd5, 32'hFFFF_FFFF, 32'h1, 32'h100, 32'h20, 1'b0, 32'h0); cyc();
    chk("BGE.taken", 32'(if_a.taken), 0);
    drive(2'd0, 3'd6, 32'hFFFF_FFFF, 32'h1, 32'h100, 32'h20, 1'b0, 32'h0); cyc();
    chk("BLTU.taken", 32'(if_a.taken), 0);
    drive(2'd0, 3'd7, 32'hFFFF_FFFF, 32'h1, 32'h100, 32'h20, 1'b1, 32'h120); cyc();
    chk("BGEU.taken", 32'(if_a.taken), 1);
    drive(2'd0, 3'd0, 32'd5, 32'd5, 32'h100, 32'h20, 1'b1, 32'h120); cyc();
    chk("BEQ.taken", 32'(if_a.taken), 1);
    chk("BEQ.target", if_a.target, 32'h120);
    chk("BEQ.mispredict", 32'(if_a.mispredict), 0);

    // JALR alignment and wrap
    drive(2'd2, 3'd0, 32'hFFFF_FFFE, 32'h0, 32'h200, 32'd3, 1'b1, 32'h0); cyc();
    chk("JALR.target", if_a.target, 32'h0);
    chk("JALR.mispredict", 32'(if_a.mispredict), 0);
    drive(2'd2, 3'd0, 32'hFFFF_FFFE, 32'h0, 32'h200, 32'd3, 1'b1, 32'h4); cyc();
    chk("JALR4.mispredict", 32'(if_a.mispredict), 1);
    chk("JALR4.redirect_pc", if_a.redirect_pc, 32'h0);

    // shadow, back-to-back
    do_reset();
    bad_bne(); cyc();
    chk("shadow.mis.valid", 32'(if_a.out_valid), 1);
    chk("shadow.mis.mispredict", 32'(if_a.mispredict), 1);
    good_beq(); cyc();
    chk("shadow.sq1.valid", 32'(if_a.out_valid), 0);
    cyc();
    chk("shadow.sq2.valid", 32'(if_a.out_valid), 0);
    cyc();
    chk("shadow.third.valid", 32'(if_a.out_valid), 1);
    idle();
    chk("shadow.br_count", 32'(if_a.br_count), 2);
    chk("shadow.mis_count", 32'(if_a.mis_count), 1);

    // shadow with an idle cycle inside the window
    do_reset();
    bad_bne(); cyc();
    good_beq(); cyc();
    idle(); cyc();
    chk("shadow_idle.gap.valid", 32'(if_a.out_valid), 0);
    good_beq(); cyc();
    chk("shadow_idle.sq2.valid", 32'(if_a.out_valid), 0);
    cyc();
    chk("shadow_idle.third.valid", 32'(if_a.out_valid), 1);
    idle();
    chk("shadow_idle.br_count", 32'(if_a.br_count), 2);
    chk("shadow_idle.mis_count", 32'(if_a.mis_count), 1);

    // stall holds, flush wins over stall and clears the shadow
    do_reset();
    drive(2'd0, 3'd0, 32'd9, 32'd9, 32'h200, 32'h8, 1'b1, 32'h208); cyc();
    stall = 1'b1;
    drive(2'd1, 3'd0, 32'd0, 32'd0, 32'h900, 32'h100, 1'b0, 32'h0);
    for (int s = 0; s < 3; s++) begin
      cyc();
      chk("stall.out_valid", 32'(if_a.out_valid), 1);
      chk("stall.target", if_a.target, 32'h208);
      chk("stall.br_count", 32'(if_a.br_count), 1);
    end
    stall = 1'b0;
    bad_bne(); cyc();
    chk("preflush.mispredict", 32'(if_a.mispredict), 1);
    stall = 1'b1; flush = 1'b1; good_beq(); cyc();
    chk("flush.out_valid", 32'(if_a.out_valid), 0);
    chk("flush.mispredict", 32'(if_a.mispredict), 0);
    stall = 1'b0; flush = 1'b0; good_beq(); cyc();
    chk("postflush.out_valid", 32'(if_a.out_valid), 1);
    chk("postflush.br_count", 32'(if_a.br_count), 3);
    idle();

    // saturation on B (CNT_W=3, SHADOW=0)
    do_reset();
    bad_bne();
    repeat (10) cyc();
    idle();
    chk("sat.B.br_count", 32'(if_b.br_count), 7);
    chk("sat.B.mis_count", 32'(if_b.mis_count), 7);
    rst = 1'b1; cyc(); rst = 1'b0;
    chk("sat.rst.B.br_count", 32'(if_b.br_count), 0);
    chk("sat.rst.B.mis_count", 32'(if_b.mis_count), 0);
    chk("sat.rst.B.out_valid", 32'(if_b.out_valid), 0);
    chk("sat.rst.B.redirect_pc", if_b.redirect_pc, 0);

    // illegal funct3
    drive(2'd0, 3'd2, 32'd1, 32'd1, 32'h300, 32'h40, 1'b1, 32'h340); cyc();
    chk("illegal.illegal", 32'(if_a.illegal), 1);
    chk("illegal.taken", 32'(if_a.taken), 0);
    chk("illegal.mispredict", 32'(if_a.mispredict), 0);
    chk("illegal.redirect_pc", if_a.redirect_pc, 32'h304);
    idle(); cyc();

    // randomized traffic, checked every cycle against the model
    for (int n = 0; n < 3000; n++) begin
      rst   = ($urandom_range(0, 199) == 0);
      flush = ($urandom_range(0, 19) == 0);
      stall = ($urandom_range(0, 9) == 0);
      ro = 2'($urandom_range(0, 3));
      drive(ro, 3'($urandom_range(0, 7)), 32'($urandom_range(0, 3)) - 32'd1,
            32'($urandom_range(0, 3)) - 32'd1, $urandom, $urandom,
            1'($urandom_range(0, 1)), 32'h0);
      if ($urandom_range(0, 1) == 1) pred_target = (ro == 2'd2) ? ((rs1 + imm) & 32'hFFFF_FFFE) : (pc + imm);
      if ($urandom_range(0, 3) == 0) begin rs1 = $urandom; rs2 = $urandom; end
      in_valid = ($urandom_range(0, 9) < 7);
      cyc();
    end
    rst = 1'b0; stall = 1'b0; flush = 1'b0; idle(); cyc();

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
